// File: rtl/pcs_receive_pkg.sv
// Shared definitions for the 1000BASE-X PCS receive path: code-group octets,
// GMII substitution values, the lookahead entry record and the one-hot
// receive state encoding.
package pcs_receive_pkg;

    // Control (K) code-group octets
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] CG_S  = 8'hFB;   // start of packet
    localparam logic [7:0] CG_T  = 8'hFD;   // end of packet
    localparam logic [7:0] CG_R  = 8'hF7;   // carrier extend
    localparam logic [7:0] CG_V  = 8'hFE;   // error propagation

    // Data (D) code-group octets that follow K28.5 in ordered sets
    localparam logic [7:0] D21_5 = 8'hB5;   // /C1/ configuration
    localparam logic [7:0] D2_2  = 8'h42;   // /C2/ configuration
    localparam logic [7:0] D5_6  = 8'hC5;   // /I1/ idle
    localparam logic [7:0] D16_2 = 8'h50;   // /I2/ idle

    // Octets placed on RXD in place of the received code-group
    localparam logic [7:0] GMII_SFD             = 8'h55;
    localparam logic [7:0] GMII_FALSE_CARRIER   = 8'h0E;
    localparam logic [7:0] GMII_CARRIER_EXTEND  = 8'h0F;

    // One buffered code-group as delivered by the decoder
    typedef struct packed {
        logic       valid;
        logic       k;
        logic [7:0] data;
        logic       even;
    } cg_t;

    localparam cg_t CG_EMPTY = '0;

    // Receive state machine, one-hot
    typedef enum logic [9:0] {
        ST_LINK_FAILED = 10'b00_0000_0001,
        ST_WAIT_FOR_K  = 10'b00_0000_0010,
        ST_RX_K        = 10'b00_0000_0100,
        ST_IDLE_D      = 10'b00_0000_1000,
        ST_RECEIVE     = 10'b00_0001_0000,
        ST_TRI_RRI     = 10'b00_0010_0000,  // first /R/ after /T/
        ST_TRR_R2      = 10'b00_0100_0000,  // second /R/ or K28.5
        ST_TRR_END     = 10'b00_1000_0000,  // after /T/R/R/
        ST_TRR_EXTEND  = 10'b01_0000_0000,  // carrier extension in progress
        ST_RX_INVALID  = 10'b10_0000_0000
    } state_t;

    // Valid control code-group carrying a specific octet
    function automatic logic is_kchar(input cg_t cg, input logic [7:0] code);
        return cg.valid && cg.k && (cg.data == code);
    endfunction

    // Any valid data code-group
    function automatic logic is_dchar(input cg_t cg);
        return cg.valid && !cg.k;
    endfunction

    // Valid data code-group carrying a specific octet
    function automatic logic is_dcode(input cg_t cg, input logic [7:0] code);
        return cg.valid && !cg.k && (cg.data == code);
    endfunction

endpackage

// File: rtl/pcs_receive_lookahead.sv
// pcs_rx_lookahead: code-group shift register feeding the receive state
// machine. stage[0] (cg0) is the oldest entry and the one being decided on;
// cg1/cg2 are the following code-groups used for /T/R/R/ detection.
module pcs_rx_lookahead
    import pcs_receive_pkg::*;
#(
    parameter int LOOKAHEAD = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  cg_t  cg_in,
    output cg_t  cg0,
    output cg_t  cg1,
    output cg_t  cg2
);

    cg_t stage [0:LOOKAHEAD];

    // Shift one code-group per clock, newest enters at the top
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: every entry is reset so stale code-groups cannot be
            // mistaken for a valid ordered set right after reset.
            for (int i = 0; i <= LOOKAHEAD; i++) begin
                stage[i] <= CG_EMPTY;
            end
        end else begin
            // NOTE: non-blocking updates let all stages shift from their
            // old values in the same edge; blocking would collapse the chain.
            for (int i = 0; i < LOOKAHEAD; i++) begin
                stage[i] <= stage[i+1];
            end
            stage[LOOKAHEAD] <= cg_in;
        end
    end

    assign cg0 = stage[0];
    assign cg1 = stage[1];
    assign cg2 = stage[LOOKAHEAD];

endmodule

// File: rtl/pcs_receive.sv
// pcs_receive: reduced 1000BASE-X PCS receive state machine. Takes decoded
// code-groups, buffers two code-groups of lookahead and drives the GMII
// receive signals. Outputs are registered; a code-group captured on edge n
// is reflected on RXD/RX_DV/RX_ER after edge n+3.
// Optional feature: define PCS_RX_CARRIER_EXTEND_EN to accept carrier
// extension (/R/ beyond /T/R/R/) and packet bursting (/R/ then /S/).
module pcs_receive
    import pcs_receive_pkg::*;
#(
    parameter int LOOKAHEAD = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sync_status,
    input  logic       rx_cg_valid,
    input  logic       rx_is_k,
    input  logic [7:0] rx_data,
    input  logic       rx_even,
    output logic [7:0] RXD,
    output logic       RX_DV,
    output logic       RX_ER,
    output logic       receiving
);

    cg_t    cg_in;
    cg_t    cg0;
    cg_t    cg1;
    cg_t    cg2;
    state_t state;
    state_t state_nxt;
    logic [7:0] rxd_nxt;
    logic       dv_nxt;
    logic       er_nxt;
    logic       rcv_nxt;
    logic       k28_5_even;
    logic       trr_ahead;
    logic       unused_even;

    assign cg_in = '{valid: rx_cg_valid, k: rx_is_k, data: rx_data, even: rx_even};

    pcs_rx_lookahead #(
        .LOOKAHEAD (LOOKAHEAD)
    ) u_lookahead (
        .clk     (clk),
        .reset_n (reset_n),
        .cg_in   (cg_in),
        .cg0     (cg0),
        .cg1     (cg1),
        .cg2     (cg2)
    );

    // Parity only matters for the code-group being decided on
    assign unused_even = cg1.even ^ cg2.even;

    assign k28_5_even = is_kchar(cg0, K28_5) && cg0.even;

    // /T/ is a clean end only when followed by /R/ and then /R/ or K28.5
    assign trr_ahead = is_kchar(cg0, CG_T) && is_kchar(cg1, CG_R) &&
                       (is_kchar(cg2, CG_R) || is_kchar(cg2, K28_5));

    // Next-state and next-output decisions on cg0
    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // path through the case leaves a value unassigned (no latches).
        state_nxt = state;
        rxd_nxt   = 8'h00;
        dv_nxt    = 1'b0;
        er_nxt    = 1'b0;
        rcv_nxt   = 1'b0;

        if (!sync_status) begin
            // Loss of sync overrides everything; outputs drop at once
            state_nxt = ST_LINK_FAILED;
        end else begin
            unique case (state)
                ST_LINK_FAILED: begin
                    state_nxt = ST_WAIT_FOR_K;
                end

                ST_WAIT_FOR_K, ST_RX_INVALID: begin
                    if (k28_5_even) begin
                        state_nxt = ST_RX_K;
                    end
                end

                ST_RX_K: begin
                    if (is_dcode(cg0, D21_5) || is_dcode(cg0, D2_2)) begin
                        state_nxt = ST_WAIT_FOR_K;      // config set, ignored
                    end else if (is_dcode(cg0, D5_6) || is_dcode(cg0, D16_2)) begin
                        state_nxt = ST_IDLE_D;
                    end else begin
                        state_nxt = ST_RX_INVALID;
                    end
                end

                ST_IDLE_D: begin
                    if (is_kchar(cg0, K28_5)) begin
                        state_nxt = ST_RX_K;
                    end else if (is_kchar(cg0, CG_S)) begin
                        // Start of packet: /S/ is replaced by the SFD octet
                        state_nxt = ST_RECEIVE;
                        rxd_nxt   = GMII_SFD;
                        dv_nxt    = 1'b1;
                        rcv_nxt   = 1'b1;
                    end else if (is_kchar(cg0, CG_V) || !is_dchar(cg0)) begin
                        // False carrier: flagged for exactly one code-group
                        state_nxt = ST_WAIT_FOR_K;
                        rxd_nxt   = GMII_FALSE_CARRIER;
                        er_nxt    = 1'b1;
                    end else begin
                        state_nxt = ST_RX_INVALID;
                    end
                end

                ST_RECEIVE: begin
                    if (is_dchar(cg0)) begin
                        rxd_nxt = cg0.data;
                        dv_nxt  = 1'b1;
                        rcv_nxt = 1'b1;
                    end else if (trr_ahead) begin
                        state_nxt = ST_TRI_RRI;         // RX_DV falls on /T/
                    end else if (is_kchar(cg0, K28_5)) begin
                        // Early end: packet cut short by an ordered set
                        state_nxt = ST_RX_K;
                        er_nxt    = 1'b1;
                    end else begin
                        // Bad code-group inside a frame: mark it, keep going
                        rxd_nxt = cg0.data;
                        dv_nxt  = 1'b1;
                        er_nxt  = 1'b1;
                        rcv_nxt = 1'b1;
                    end
                end

                ST_TRI_RRI: begin
                    // cg0 is the first /R/, guaranteed by the lookahead check
                    state_nxt = ST_TRR_R2;
                end

                ST_TRR_R2: begin
                    if (is_kchar(cg0, CG_R)) begin
                        state_nxt = ST_TRR_END;
                    end else if (is_kchar(cg0, K28_5)) begin
                        state_nxt = ST_RX_K;
                    end else begin
                        state_nxt = ST_RX_INVALID;
                    end
                end

                ST_TRR_END, ST_TRR_EXTEND: begin
                    if (is_kchar(cg0, K28_5)) begin
                        state_nxt = ST_RX_K;
`ifdef PCS_RX_CARRIER_EXTEND_EN
                    end else if (is_kchar(cg0, CG_R)) begin
                        // Carrier extension, one GMII slot per extra /R/
                        state_nxt = ST_TRR_EXTEND;
                        rxd_nxt   = GMII_CARRIER_EXTEND;
                        er_nxt    = 1'b1;
                    end else if (is_kchar(cg0, CG_S)) begin
                        // Packet burst: /S/ straight after /R/
                        state_nxt = ST_RECEIVE;
                        rxd_nxt   = GMII_SFD;
                        dv_nxt    = 1'b1;
                        rcv_nxt   = 1'b1;
`endif
                    end else begin
                        state_nxt = ST_RX_INVALID;
                    end
                end

                default: begin
                    state_nxt = ST_LINK_FAILED;
                end
            endcase
        end
    end

    // State and registered GMII outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_LINK_FAILED;
            RXD       <= 8'h00;
            RX_DV     <= 1'b0;
            RX_ER     <= 1'b0;
            receiving <= 1'b0;
        end else begin
            state     <= state_nxt;
            RXD       <= rxd_nxt;
            RX_DV     <= dv_nxt;
            RX_ER     <= er_nxt;
            receiving <= rcv_nxt;
        end
    end

endmodule

// File: doc/pcs_receive.md
Name: pcs_receive

Overview:
- Receive-side counterpart of the 1000BASE-X PCS transmit path: implements a reduced 36.2.5.2.2 receive state machine.
- Input: decoded 10b/8b code-groups from the decoder and synchronization blocks.
- Output: GMII receive signals RXD/RX_DV/RX_ER plus a receiving flag.
- Sits between the 8b/10b decoder and the GMII RX interface. xmit is treated as DATA; no auto-negotiation.

Parameters:
- LOOKAHEAD, 2, number of future code-groups buffered for /T/R/R/ end and /S/ checks; fixed at 2, other values unsupported.

Ports:
- clk  input  1  receive code-group clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- sync_status  input  1  1 = code-group sync OK (OK), 0 = FAIL.
- rx_cg_valid  input  1  current code-group is a valid 10b code (not /INVALID/).
- rx_is_k  input  1  current code-group is a K (control) character.
- rx_data  input  8  decoded octet.
- rx_even  input  1  code-group is in an even position.
- RXD  output  8  GMII receive data.
- RX_DV  output  1  receive data valid.
- RX_ER  output  1  receive error / carrier extend.
- receiving  output  1  packet reception in progress.

Behaviour:
- Constants: K28.5=8'hBC, /S/=8'hFB, /T/=8'hFD, /R/=8'hF7, /V/=8'hFE; D21.5=8'hB5, D2.2=8'h42, D5.6=8'hC5, D16.2=8'h50.
- Lookahead: 3-entry shift register {cg0 oldest, cg1, cg2 newest}. Each entry holds {valid,k,data,even}; shifts every clk. The FSM evaluates cg0 with cg1/cg2 as lookahead.
- Latency: input to RXD/RX_DV/RX_ER is exactly 3 clk, outputs registered.
- Reset (async, reset_n=0):
  - outputs: RXD=8'h00, RX_DV=0, RX_ER=0, receiving=0.
  - lookahead entries cleared to invalid; FSM=LINK_FAILED.
- States and transitions:
  - LINK_FAILED: RX_DV=0, RX_ER=0. Go to WAIT_FOR_K when sync_status=1.
  - WAIT_FOR_K: wait for cg0=K28.5 with even=1 -> RX_K.
  - RX_K: the following cg0 must be a D character.
    - D21.5 or D2.2 -> WAIT_FOR_K (config ordered set, ignored).
    - D5.6 or D16.2 -> IDLE_D.
    - otherwise -> RX_INVALID.
  - IDLE_D:
    - cg0=K28.5 -> RX_K.
    - cg0=/S/ -> START_OF_PACKET. Output RX_DV=1, RXD=8'h55 (SFD substitution per 36.2.5.2.2), receiving=1.
    - any other K or invalid -> FALSE_CARRIER. Output RX_ER=1, RXD=8'h0E, for one code-group, then WAIT_FOR_K.
  - RECEIVE (entered after START_OF_PACKET):
    - valid D -> RXD=cg0.data, RX_DV=1.
    - cg0=/T/ and cg1=/R/ and cg2 in {/R/,K28.5} -> TRI_RRI. RX_DV=0, receiving=0 after that code-group.
    - cg0=K28.5 (early end) -> EARLY_END. RX_DV=0, RX_ER=1 one cycle, then RX_K.
    - any other K or invalid -> RX_DATA_ERROR. RX_DV=1, RX_ER=1, RXD=cg0.data; stay in RECEIVE.
  - TRI_RRI: skips the two /R/ code-groups, outputs idle, then RX_K on K28.5.
  - RX_INVALID: RX_ER=0, RX_DV=0. Return to WAIT_FOR_K on the next K28.5 even.
- sync_status=0 in any state: next clk go to LINK_FAILED, drop RX_DV/RX_ER/receiving immediately (no drain of lookahead).
- Simultaneous: loss of sync dominates all code-group decisions. /S/ in odd position is still accepted.
- A packet in flight when sync drops ends with RX_DV falling with no RX_ER (per standard).

Optional Feature:
- Macro: PCS_RX_CARRIER_EXTEND_EN.
- Defined:
  - /T/R/R/ followed by further /R/ enters TRR_EXTEND. Output RX_DV=0, RX_ER=1, RXD=8'h0F per extension code-group.
  - K28.5 ends the extension.
  - /S/ directly after /R/ starts a new burst packet (PACKET_BURST_RRS).
- Undefined: extra /R/ after /T/R/R/ goes to RX_INVALID with RX_ER=0; no burst support.

Decomposition:
- Shared include (alongside the code-group tables): `defines for all K/D octet constants, FSM state encodings (one-hot, 10 bits), GMII substitution values 8'h55/8'h0E/8'h0F.
- Sub-module pcs_rx_lookahead: 3-stage code-group shift register with async reset; exposes cg0..cg2 fields.

Test Plan:
- reset_n=0 then 1, sync_status=1, stream K28.5(even),D16.2 repeated -> RX_DV=0, RX_ER=0, FSM reaches IDLE_D; no output activity.
- Idle then /S/,D8'hAA,D8'h11,/T/,/R/,K28.5 -> 3 clk later RXD=55,AA,11 with RX_DV=1; RX_DV falls on the /T/ slot; RX_ER never 1.
- Idle then /V/ -> RX_ER=1, RXD=8'h0E for one cycle, RX_DV=0, then back to idle after the next K28.5.
- Mid-packet invalid code-group (rx_cg_valid=0) -> RX_DV=1, RX_ER=1 for that slot only; data resumes.
- sync_status drops mid-packet -> RX_DV, RX_ER and receiving are 0 on the next clk; FSM goes to LINK_FAILED.
- With PCS_RX_CARRIER_EXTEND_EN: /T/,/R/,/R/,/R/,K28.5 -> one slot with RX_ER=1, RXD=8'h0F, RX_DV=0. Without the macro, the same stream gives RX_ER=0.
